// File: rtl/modpow_pkg.sv
// Shared types and helpers for the modular-exponentiation scheduler.
package modpow_pkg;

    localparam int unsigned MODPOW_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } sched_state_t;

    typedef struct packed {
        logic [MODPOW_W-1:0] x;
        logic [MODPOW_W-1:0] y;
        logic [MODPOW_W-1:0] n;
    } modpow_job_t;

    // (base + off) mod n, for base < n and off <= n.
    function automatic int unsigned rr_wrap(input int unsigned base, input int unsigned off,
                                            input int unsigned n);
        int unsigned s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins, with wrap.
module rr_arbiter
    import modpow_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDXW-1:0] idx_o
);

    logic            found_c;
    logic [IDXW-1:0] sel_c;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_c = 1'b0;
        sel_c   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sel_c = IDXW'(rr_wrap(32'(ptr_i), i, NREQ));
            if (!found_c && req_i[sel_c]) begin
                gnt_o[sel_c] = 1'b1;
                idx_o        = sel_c;
                found_c      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/modpow_sched.sv
// Shares one modpow engine among NREQ requesters, one job in flight at a time.
// Define MODPOW_SCHED_TIMEOUT_EN to abort a hung engine job after TMO_CYC wait cycles.
module modpow_sched
    import modpow_pkg::*;
#(
    parameter int unsigned MBIT    = 63,
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TMO_CYC = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*(MBIT+1)-1:0] req_x,
    input  logic [NREQ*(MBIT+1)-1:0] req_y,
    input  logic [NREQ*(MBIT+1)-1:0] req_n,
    output logic [NREQ-1:0]          rsp_valid,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [MBIT:0]            rsp_res,
    output logic                     rsp_err,
    output logic                     eng_start,
    output logic [MBIT:0]            eng_x,
    output logic [MBIT:0]            eng_y,
    output logic [MBIT:0]            eng_n,
    input  logic                     eng_busy,
    input  logic [MBIT:0]            eng_res,
    output logic                     sched_busy
);

    localparam int unsigned W    = MBIT + 1;
    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_t    state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [W-1:0]    eng_x_q, eng_x_d, eng_y_q, eng_y_d, eng_n_q, eng_n_d;
    logic            eng_start_q, eng_start_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_res_q, rsp_res_d;
    logic            sched_busy_q, sched_busy_d;
    logic            seen_q, seen_d;
    logic [NREQ-1:0] gnt;
    logic [IDXW-1:0] gnt_idx;

`ifdef MODPOW_SCHED_TIMEOUT_EN
    logic            rsp_err_q, rsp_err_d;
    logic [31:0]     cnt_q, cnt_d;
`else
    logic            unused_tmo;
    assign unused_tmo = |TMO_CYC;
`endif

    rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    // Acceptance is only offered while idle and out of reset.
    assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        eng_x_d     = eng_x_q;
        eng_y_d     = eng_y_q;
        eng_n_d     = eng_n_q;
        eng_start_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        seen_d      = seen_q;
`ifdef MODPOW_SCHED_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    owner_d     = gnt_idx;
                    eng_x_d     = req_x[W*32'(gnt_idx) +: W];
                    eng_y_d     = req_y[W*32'(gnt_idx) +: W];
                    eng_n_d     = req_n[W*32'(gnt_idx) +: W];
                    eng_start_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // A zero-exponent job may pulse busy while start is still high.
                seen_d  = eng_busy;
                state_d = WAIT_BUSY;
`ifdef MODPOW_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT_BUSY: begin
                if (eng_busy || seen_q) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!eng_busy) begin
                    rsp_res_d   = eng_res;
                    rsp_valid_d = NREQ'(1) << owner_q;
                    state_d     = RESP;
`ifdef MODPOW_SCHED_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                end
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    ptr_d       = IDXW'(rr_wrap(32'(owner_q), 1, NREQ));
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MODPOW_SCHED_TIMEOUT_EN
        // Watchdog: a normal completion in the same cycle takes priority.
        if (state_q == WAIT_BUSY || state_q == WAIT_DONE) begin
            cnt_d = cnt_q + 32'd1;
            if (state_d != RESP && cnt_d == TMO_CYC) begin
                rsp_res_d   = '0;
                rsp_err_d   = 1'b1;
                rsp_valid_d = NREQ'(1) << owner_q;
                state_d     = RESP;
            end
        end
`endif
        sched_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            eng_x_q      <= '0;
            eng_y_q      <= '0;
            eng_n_q      <= '0;
            eng_start_q  <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_res_q    <= '0;
            sched_busy_q <= 1'b0;
            seen_q       <= 1'b0;
`ifdef MODPOW_SCHED_TIMEOUT_EN
            rsp_err_q    <= 1'b0;
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            eng_x_q      <= eng_x_d;
            eng_y_q      <= eng_y_d;
            eng_n_q      <= eng_n_d;
            eng_start_q  <= eng_start_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_res_q    <= rsp_res_d;
            sched_busy_q <= sched_busy_d;
            seen_q       <= seen_d;
`ifdef MODPOW_SCHED_TIMEOUT_EN
            rsp_err_q    <= rsp_err_d;
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign eng_x      = eng_x_q;
    assign eng_y      = eng_y_q;
    assign eng_n      = eng_n_q;
    assign eng_start  = eng_start_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_res    = rsp_res_q;
    assign sched_busy = sched_busy_q;
`ifdef MODPOW_SCHED_TIMEOUT_EN
    assign rsp_err    = rsp_err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_modpow_sched.sv
// Directed bench for modpow_sched with a behavioural engine; define MODPOW_SCHED_TIMEOUT_EN for the watchdog case.
module tb_modpow_sched;
    import modpow_pkg::*;

`ifdef MODPOW_SCHED_TIMEOUT_EN
    localparam int unsigned TMO = 16;
`else
    localparam int unsigned TMO = 65535;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [127:0]  req_x, req_y, req_n;
    logic [63:0]   rsp_res, eng_x, eng_y, eng_n, eng_res;
    logic          rsp_err, eng_start, eng_busy, sched_busy;

    int nchk = 0;
    int nerr = 0;
    int starts = 0;
    int s0, cyc;
    logic seen_rv;

    // Engine model controls.
    int          lat_cfg;
    logic        hang, comb_mode;
    logic        busy_q = 1'b0;
    int          cnt_e = 0;
    logic [63:0] res_q = '0;

    always #5 clk = ~clk;

    modpow_sched #(.MBIT(63), .NREQ(2), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_n(req_n),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_err(rsp_err),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y), .eng_n(eng_n),
        .eng_busy(eng_busy), .eng_res(eng_res), .sched_busy(sched_busy)
    );

    function automatic logic [63:0] modpow(input logic [63:0] b, input logic [63:0] e,
                                           input logic [63:0] m);
        logic [127:0] r, bb, mm;
        mm = {64'd0, m};
        r  = 128'd1 % mm;
        bb = {64'd0, b} % mm;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * bb) % mm;
            bb = (bb * bb) % mm;
        end
        return r[63:0];
    endfunction

    // Engine: busy for lat_cfg cycles after start, result garbage while busy.
    always @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_e  <= 0;
        end else if (eng_start) begin
            res_q <= modpow(eng_x, eng_y, eng_n);
            if (!comb_mode) begin
                busy_q <= 1'b1;
                cnt_e  <= lat_cfg;
            end
        end else if (busy_q && !hang) begin
            if (cnt_e <= 1) busy_q <= 1'b0;
            else cnt_e <= cnt_e - 1;
        end
    end
    assign eng_busy = comb_mode ? eng_start : busy_q;
    assign eng_res  = eng_busy ? 64'hDEAD_BEEF_DEAD_BEEF : res_q;

    always @(posedge clk) if (eng_start) starts <= starts + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_job(input int i, input logic [63:0] x, input logic [63:0] y,
                           input logic [63:0] n);
        req_x[i*64 +: 64] = x;
        req_y[i*64 +: 64] = y;
        req_n[i*64 +: 64] = n;
    endtask

    task automatic wait_rsp(input int max_cyc, input string tag, output int c);
        c = 0;
        while (rsp_valid == 2'b00 && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        check(tag, 64'(rsp_valid != 2'b00), 64'd1);
    endtask

    task automatic respond(input logic [1:0] who);
        rsp_ready = who;
        @(negedge clk);
        rsp_ready = 2'b00;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_n = '0; rsp_ready = '0;
        lat_cfg = 5; hang = 1'b0; comb_mode = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state, including no acceptance while rst is high.
        req_valid = 2'b11;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_res", rsp_res, 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_eng_start", 64'(eng_start), 64'd0);
        check("rst_eng_xyn", 64'(eng_x | eng_y | eng_n), 64'd0);
        check("rst_sched_busy", 64'(sched_busy), 64'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single job from requester 0.
        s0 = starts;
        set_job(0, 64'd4, 64'd13, 64'd497);
        req_valid = 2'b01;
        #1 check("t1_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 2'b00;
        check("t1_eng_start", 64'(eng_start), 64'd1);
        check("t1_eng_x", eng_x, 64'd4);
        check("t1_eng_y", eng_y, 64'd13);
        check("t1_eng_n", eng_n, 64'd497);
        check("t1_sched_busy", 64'(sched_busy), 64'd1);
        wait_rsp(40, "t1_rsp_arrived", cyc);
        check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t1_rsp_res", rsp_res, 64'd445);
        check("t1_rsp_err", 64'(rsp_err), 64'd0);
        check("t1_one_start", 64'(starts - s0), 64'd1);
        respond(2'b01);
        check("t1_rsp_cleared", 64'(rsp_valid), 64'd0);
        check("t1_idle", 64'(sched_busy), 64'd0);

        // Simultaneous requests after reset: pointer 0 picks req0, then req1 wins the next pair.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_job(0, 64'd2, 64'd10, 64'd1000);
        set_job(1, 64'd3, 64'd5, 64'd7);
        req_valid = 2'b11;
        #1 check("t2_grant0", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 2'b10;
        #1 check("t2_no_grant_busy", 64'(req_ready), 64'd0);
        wait_rsp(40, "t2a_rsp_arrived", cyc);
        check("t2a_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t2a_rsp_res", rsp_res, 64'd24);
        rsp_ready = 2'b10;
        @(negedge clk);
        check("t2_nonowner_ignored", 64'(rsp_valid), 64'd1);
        rsp_ready = 2'b01;
        req_valid = 2'b11;
        @(negedge clk);
        rsp_ready = 2'b00;
        check("t2_grant1_first", 64'(req_ready), 64'd2);
        check("t2a_rsp_cleared", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        req_valid = 2'b01;
        wait_rsp(40, "t2b_rsp_arrived", cyc);
        check("t2b_rsp_valid", 64'(rsp_valid), 64'd2);
        check("t2b_rsp_res", rsp_res, 64'd5);
        respond(2'b10);
        check("t2c_grant0", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(40, "t2c_rsp_arrived", cyc);
        check("t2c_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t2c_rsp_res", rsp_res, 64'd24);
        respond(2'b01);

        // Zero exponent, one-cycle engine.
        lat_cfg = 1;
        set_job(0, 64'd9, 64'd0, 64'd11);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(20, "t3_rsp_arrived", cyc);
        check("t3_rsp_res", rsp_res, 64'd1);
        check("t3_rsp_err", 64'(rsp_err), 64'd0);
        respond(2'b01);

        // Zero exponent, engine busy only during the start cycle.
        comb_mode = 1'b1;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(20, "t3c_rsp_arrived", cyc);
        check("t3c_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t3c_rsp_res", rsp_res, 64'd1);
        respond(2'b01);
        comb_mode = 1'b0;

        // Back-pressure: response held 20 cycles while req0 waits.
        lat_cfg = 3;
        set_job(1, 64'd3, 64'd5, 64'd7);
        req_valid = 2'b10;
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(30, "t4_rsp_arrived", cyc);
        set_job(0, 64'd4, 64'd13, 64'd497);
        req_valid = 2'b01;
        s0 = starts;
        #1;
        for (int i = 0; i < 20; i++) begin
            check("t4_hold_valid", 64'(rsp_valid), 64'd2);
            check("t4_hold_res", rsp_res, 64'd5);
            check("t4_hold_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        check("t4_no_start", 64'(starts - s0), 64'd0);
        respond(2'b10);
        check("t4_idle_grant", 64'(req_ready), 64'd1);
        check("t4_rsp_cleared", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(30, "t4b_rsp_arrived", cyc);
        check("t4b_rsp_res", rsp_res, 64'd445);
        respond(2'b01);

        // Reset during WAIT_DONE abandons the job.
        lat_cfg = 8;
        set_job(0, 64'd2, 64'd10, 64'd1000);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        check("t5_in_wait", 64'(sched_busy & eng_busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t5_rst_outputs", 64'(eng_start | sched_busy | rsp_err), 64'd0);
        check("t5_rst_eng_x", eng_x, 64'd0);
        check("t5_rst_rsp_res", rsp_res, 64'd0);
        rst = 1'b0;
        seen_rv = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen_rv = seen_rv | (|rsp_valid);
        end
        check("t5_no_stale_rsp", 64'(seen_rv), 64'd0);
        set_job(1, 64'd3, 64'd5, 64'd7);
        req_valid = 2'b10;
        #1 check("t5_new_grant", 64'(req_ready), 64'd2);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(40, "t5_rsp_arrived", cyc);
        check("t5_rsp_valid", 64'(rsp_valid), 64'd2);
        check("t5_rsp_res", rsp_res, 64'd5);
        respond(2'b10);

`ifdef MODPOW_SCHED_TIMEOUT_EN
        // Hung engine: error response after 16 wait-state cycles.
        hang = 1'b1;
        set_job(0, 64'd4, 64'd13, 64'd497);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(40, "t6_rsp_arrived", cyc);
        check("t6_latency", 64'(cyc), 64'd17);
        check("t6_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t6_rsp_err", 64'(rsp_err), 64'd1);
        check("t6_rsp_res", rsp_res, 64'd0);
        respond(2'b01);
        hang = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule

// File: doc/modpow_sched.md
Name: modpow_sched

Overview:
- Round-robin scheduler that shares one modular-exponentiation engine between NREQ requesters (e.g. encrypt and decrypt paths of the RSA core).
- Accepts jobs (base, exponent, modulus) over per-requester valid/ready handshakes.
- Issues each job to the engine with a one-cycle start pulse, waits for completion, and returns the result to the owning requester.
- Sits between the RSA top-level control and the modpow engine.

Parameters:
- MBIT, 63: MSB index of operands; data width is MBIT+1.
- NREQ, 2: number of requesters (2..8).
- TMO_CYC, 65535: watchdog limit in cycles. Used only with MODPOW_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  job offered by requester i.
- req_ready  out  NREQ  job accepted from requester i this cycle.
- req_x  in  NREQ*(MBIT+1)  base, packed, requester i at slice i.
- req_y  in  NREQ*(MBIT+1)  exponent, packed.
- req_n  in  NREQ*(MBIT+1)  modulus, packed.
- rsp_valid  out  NREQ  result available for requester i.
- rsp_ready  in  NREQ  requester i consumes result.
- rsp_res  out  MBIT+1  result; shared bus, qualified by rsp_valid.
- rsp_err  out  1  result invalid (timeout); qualified by rsp_valid.
- eng_start  out  1  one-cycle start pulse to engine.
- eng_x, eng_y, eng_n  out  MBIT+1 each  engine operands; held stable from ISSUE through WAIT_DONE.
- eng_busy  in  1  engine computing.
- eng_res  in  MBIT+1  engine result, valid when eng_busy falls.
- sched_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; all outputs 0: req_ready, rsp_valid, rsp_res, rsp_err, eng_start, eng_x/y/n, sched_busy.
  - Round-robin pointer = 0.
  - Reset mid-job abandons the job silently; no response is issued.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - If any req_valid, grant the lowest index at or after the pointer (wrap modulo NREQ).
  - req_ready[g]=1 for that single cycle (combinational from state and req_valid).
  - Latch operands into eng_x/y/n and latch owner g. Next state ISSUE.
- ISSUE: eng_start=1 for exactly one cycle. Next state WAIT_BUSY.
- WAIT_BUSY:
  - Wait for eng_busy=1, then go to WAIT_DONE.
  - If req_y==0 the engine may finish immediately, so a busy pulse already seen in the ISSUE cycle counts as risen.
- WAIT_DONE: on eng_busy=0, capture eng_res into rsp_res, rsp_err=0. Next state RESP.
- RESP:
  - rsp_valid[owner]=1; all other bits 0.
  - Hold until rsp_ready[owner]=1.
  - Then clear rsp_valid, set pointer=owner+1 (wrap), return to IDLE.
- Throughput/latency:
  - At most one job in flight; no new grant while a job is outstanding.
  - Minimum latency from accept to rsp_valid = engine time + 3 cycles.
- Arbitration:
  - Simultaneous valids: pointer decides; no requester starves.
  - A requester may hold req_valid across cycles; acceptance happens only on the req_ready cycle.
- Responses: rsp_ready on a non-owner bit is ignored; rsp_ready while rsp_valid=0 is ignored.
- Widths: operands passed through unmodified; no arithmetic in this block.
- Modulus 0: forwarded to the engine as-is (result undefined). Validating it is the requester's job.

Optional Feature:
- Macro: MODPOW_SCHED_TIMEOUT_EN.
- With the macro defined:
  - A 32-bit counter clears on ISSUE and increments in WAIT_BUSY and WAIT_DONE.
  - When it reaches TMO_CYC: go to RESP with rsp_res=0, rsp_err=1.
  - The engine is not reset by this block; the next job issues normally.
- Without the macro: no counter; rsp_err tied 0; the block waits indefinitely.

Decomposition:
- Shared package modpow_pkg holds:
  - sched_state_t enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP);
  - localparam for the default width 64;
  - typedef modpow_job_t struct {x, y, n}.
- Sub-module rr_arbiter: NREQ-bit request vector plus pointer in, one-hot grant and index out, purely combinational.

Test Plan:
- Single job from req 0: x=4, y=13, n=497 -> one eng_start pulse, rsp_valid[0] with rsp_res=445, rsp_err=0.
- Both requesters valid in the same cycle after reset: req0 (2,10,1000), req1 (3,5,7) -> req0 served first with res 24, then req1 with res 5; the next simultaneous pair grants req1 first.
- Zero exponent: x=9, y=0, n=11 -> rsp_res=1 with no hang, including an engine that drops busy after 1 cycle.
- Back-pressure: hold rsp_ready=0 for 20 cycles -> rsp_valid and rsp_res stable, req_ready stays 0, no eng_start; release -> IDLE next cycle.
- rst=1 asserted in WAIT_DONE -> next cycle all outputs 0, no rsp_valid; a new job completes correctly.
- With MODPOW_SCHED_TIMEOUT_EN and TMO_CYC=16, engine holds busy forever -> rsp_valid with rsp_err=1, rsp_res=0 after 16 cycles in wait states.
